// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared constants and helpers for the write-back arbiter
package writeback_arbiter_pkg;
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;
  function automatic int addr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_holding_slot.sv
// wb_holding_slot: one-entry write-back buffer with ready generation and clear-on-grant
module wb_holding_slot #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data,
  input  logic          clear,
  output logic          ready,
  output logic          full,
  output logic [AW-1:0] q_address,
  output logic [DW-1:0] q_data
);
  typedef struct packed {
    logic          full;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
  } slot_t;
  slot_t slot;
  // a slot drained this cycle can refill on the same edge
  assign ready = !slot.full || clear;
  assign full = slot.full;
  assign q_address = slot.address;
  assign q_data = slot.data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot <= '0;
    else if (valid && ready) slot <= '{1'b1, address, data};
    else if (clear) slot.full <= 1'b0;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin merge of ALU and load write-backs into one registered write
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int P_BitWidth = 32,
  parameter int P_DataWidth = 32,
  parameter int P_ZeroReg = 1,
  localparam int AW = addr_width(P_BitWidth)
) (
  input  logic                   In_Clock,
  input  logic                   In_Reset_n,
  input  logic                   In_AluValid,
  input  logic [AW-1:0]          In_AluAddress,
  input  logic [P_DataWidth-1:0] In_AluData,
  output logic                   Out_AluReady,
  input  logic                   In_MemValid,
  input  logic [AW-1:0]          In_MemAddress,
  input  logic [P_DataWidth-1:0] In_MemData,
  output logic                   Out_MemReady,
  output logic [AW-1:0]          Out_Address,
  output logic                   Out_Enable,
  output logic [P_DataWidth-1:0] Out_Data,
  output logic                   Out_Grant
);
  localparam logic ZERO_SKIP = P_ZeroReg != 0;
  logic alu_full, mem_full, gnt_alu, gnt_mem, last;
  logic [AW-1:0] alu_addr, mem_addr, sel_addr;
  logic [P_DataWidth-1:0] alu_data, mem_data, sel_data;
  wb_holding_slot #(.AW(AW), .DW(P_DataWidth)) u_alu (
    .clk(In_Clock), .rst_n(In_Reset_n), .valid(In_AluValid), .address(In_AluAddress),
    .data(In_AluData), .clear(gnt_alu), .ready(Out_AluReady), .full(alu_full),
    .q_address(alu_addr), .q_data(alu_data)
  );
  wb_holding_slot #(.AW(AW), .DW(P_DataWidth)) u_mem (
    .clk(In_Clock), .rst_n(In_Reset_n), .valid(In_MemValid), .address(In_MemAddress),
    .data(In_MemData), .clear(gnt_mem), .ready(Out_MemReady), .full(mem_full),
    .q_address(mem_addr), .q_data(mem_data)
  );
  // on a tie the source not granted last wins
  always_comb begin
    gnt_mem = mem_full && (!alu_full || last == GRANT_ALU);
    gnt_alu = alu_full && !gnt_mem;
    sel_addr = gnt_mem ? mem_addr : alu_addr;
    sel_data = gnt_mem ? mem_data : alu_data;
  end
  always_ff @(posedge In_Clock or negedge In_Reset_n)
    if (!In_Reset_n) begin
      Out_Enable <= 1'b0;
      Out_Address <= '0;
      Out_Data <= '0;
      Out_Grant <= GRANT_ALU;
      last <= GRANT_ALU;
    end else if (gnt_alu || gnt_mem) begin
      Out_Enable <= !(ZERO_SKIP && sel_addr == '0);
      Out_Address <= sel_addr;
      Out_Data <= sel_data;
      Out_Grant <= gnt_mem ? GRANT_MEM : GRANT_ALU;
      last <= gnt_mem ? GRANT_MEM : GRANT_ALU;
    end else Out_Enable <= 1'b0;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: scoreboard bench, P_ZeroReg=1 and P_ZeroReg=0 instances on shared stimulus
module tb_writeback_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic av, mv;
  logic [4:0] aa, ma;
  logic [31:0] ad, md;
  logic r1_a, r1_m, en1, g1, r0_a, r0_m, en0, g0;
  logic [4:0] addr1, addr0;
  logic [31:0] data1, data0;
  logic [37:0] q1[$], q0[$];
  logic [31:0] rf[32];
  int compared = 0;
  int mismatched = 0;
  int ai, mi;

  always #5 clk = ~clk;

  writeback_arbiter #(.P_BitWidth(32), .P_DataWidth(32), .P_ZeroReg(1)) dut (
    .In_Clock(clk), .In_Reset_n(rst_n),
    .In_AluValid(av), .In_AluAddress(aa), .In_AluData(ad), .Out_AluReady(r1_a),
    .In_MemValid(mv), .In_MemAddress(ma), .In_MemData(md), .Out_MemReady(r1_m),
    .Out_Address(addr1), .Out_Enable(en1), .Out_Data(data1), .Out_Grant(g1)
  );
  writeback_arbiter #(.P_BitWidth(32), .P_DataWidth(32), .P_ZeroReg(0)) dut_nz (
    .In_Clock(clk), .In_Reset_n(rst_n),
    .In_AluValid(av), .In_AluAddress(aa), .In_AluData(ad), .Out_AluReady(r0_a),
    .In_MemValid(mv), .In_MemAddress(ma), .In_MemData(md), .Out_MemReady(r0_m),
    .Out_Address(addr0), .Out_Enable(en0), .Out_Data(data0), .Out_Grant(g0)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input logic g, input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) q1.push_back({g, a, d});
    q0.push_back({g, a, d});
  endtask

  task automatic drive(input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic v2, input logic [4:0] a2, input logic [31:0] d2);
    av = v1; aa = a1; ad = d1; mv = v2; ma = a2; md = d2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_zr1"}, {60'd0, en1, g1, r1_a, r1_m} | {26'd0, addr1, data1, 1'b0}, {60'd0, 4'b0011});
    check({name, "_zr0"}, {60'd0, en0, g0, r0_a, r0_m} | {26'd0, addr0, data0, 1'b0}, {60'd0, 4'b0011});
  endtask

  always @(negedge clk) begin
    if (en1) begin
      if (q1.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL zr1_unexpected_write: got %0h expected no write", {g1, addr1, data1});
      end else check("zr1_write", {26'd0, g1, addr1, data1}, {26'd0, q1.pop_front()});
      rf[addr1] = data1;
    end
    if (en0) begin
      if (q0.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL zr0_unexpected_write: got %0h expected no write", {g0, addr0, data0});
      end else check("zr0_write", {26'd0, g0, addr0, data0}, {26'd0, q0.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    foreach (rf[i]) rf[i] = 32'd0;
    rst_n = 1'b0;
    idle();
    #12;
    check_reset_outputs("reset_init");
    rst_n = 1'b1;
    tick();
    // single ALU write, 2-cycle latency
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    expect_wr(1'b0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    @(negedge clk);
    check("latency_not_early", {63'd0, en1}, 64'd0);
    tick();
    @(negedge clk);
    check("latency_two_cycles", {63'd0, en1}, 64'd1);
    tick();
    // back-to-back ALU writes
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
      expect_wr(1'b0, 5'(i), 32'h100 + 32'(i));
      @(negedge clk);
      check("b2b_alu_ready", {63'd0, r1_a}, 64'd1);
      tick();
    end
    idle();
    tick(4);
    // tie after reset: Mem wins first
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    expect_wr(1'b1, 5'd4, 32'h44);
    expect_wr(1'b0, 5'd3, 32'h33);
    tick();
    idle();
    @(negedge clk);
    check("tie_alu_ready_low", {62'd0, r1_a, r1_m}, 64'b01);
    tick();
    @(negedge clk);
    check("tie_alu_ready_back", {63'd0, r1_a}, 64'd1);
    tick(3);
    // sustained contention from reset
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_wr(1'b1, 5'd20 + 5'(i), 32'hB000_0000 + 32'(i));
      expect_wr(1'b0, 5'd10 + 5'(i), 32'hA000_0000 + 32'(i));
    end
    expect_wr(1'b1, 5'd24, 32'hB000_0004);
    ai = 0;
    mi = 0;
    for (int k = 0; k < 8; k++) begin
      logic ea, em;
      ea = (k % 2) == 0;
      em = (k == 0) || (k % 2) == 1;
      drive(1'b1, 5'd10 + 5'(ai), 32'hA000_0000 + 32'(ai), 1'b1, 5'd20 + 5'(mi), 32'hB000_0000 + 32'(mi));
      @(negedge clk);
      check($sformatf("rr_ready_k%0d", k), {62'd0, r1_a, r1_m}, {62'd0, ea, em});
      tick();
      if (ea) ai++;
      if (em) mi++;
    end
    idle();
    tick(5);
    // zero register write
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    expect_wr(1'b0, 5'd0, 32'h1234);
    tick();
    idle();
    tick();
    @(negedge clk);
    check("zr1_enable_suppressed", {63'd0, en1}, 64'd0);
    check("zr0_enable_addr0", {58'd0, en0, addr0}, {58'd0, 1'b1, 5'd0});
    check("zr_slot_free", {62'd0, r1_a, r0_a}, 64'b11);
    tick(2);
    // same address from both sources; pointer last = ALU so Mem goes first
    drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    expect_wr(1'b1, 5'd7, 32'h22);
    expect_wr(1'b0, 5'd7, 32'h11);
    tick();
    idle();
    tick(4);
    check("same_addr_final_value", {32'd0, rf[7]}, 64'h11);
    // reset with both slots full discards them
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
    tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_op");
    #2 rst_n = 1'b1;
    tick(5);
    check("post_reset_ready", {60'd0, r1_a, r1_m, r0_a, r0_m}, 64'hF);
    check("scoreboard_drained", {32'(q1.size()), 32'(q0.size())}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
